// File: rtl/serial_receiver_if.sv
// Chunk-in / word-out handshake bundle for serial_receiver.
// slave: the receiver side; master: the chunk source and word consumer.
interface serial_receiver_if #(
   parameter int unsigned LENGTH = 4
);
   logic [LENGTH-1:0] din;
   logic              din_valid;
   logic              rx_start;
   logic              rx_ack;
   logic [31:0]       dout;
   logic              rx_done;
   logic              rx_busy;
   logic              rx_err;

   modport slave (
      input  din, din_valid, rx_start, rx_ack,
      output dout, rx_done, rx_busy, rx_err
   );

   modport master (
      output din, din_valid, rx_start, rx_ack,
      input  dout, rx_done, rx_busy, rx_err
   );
endinterface

// File: rtl/serial_receiver.sv
// serial_receiver: reassembles one 32-bit word from LENGTH-bit chunks
// (MSB chunk first) and holds it for the consumer until acknowledged.
// Optional macro RX_TIMEOUT_EN: abandon a word after TIMEOUT idle cycles in RECV.
module serial_receiver #(
   parameter int unsigned LENGTH  = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input logic               clk,
   input logic               reset,
   serial_receiver_if.slave  bus
);
   localparam int unsigned CHUNKS = (LENGTH == 0) ? 1 : 32 / LENGTH;
   localparam logic [5:0]  LAST   = 6'(CHUNKS - 1);

   // Elaboration-time parameter legality
   if (LENGTH != 1 && LENGTH != 2 && LENGTH != 4 &&
       LENGTH != 8 && LENGTH != 16 && LENGTH != 32) begin : g_bad_length
      $error("serial_receiver: LENGTH must divide 32");
   end
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("serial_receiver: TIMEOUT must be non-zero");
   end

   typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

   state_t      state;
   logic [31:0] sreg;
   logic [5:0]  count;
   logic [31:0] shifted_c;

`ifdef RX_TIMEOUT_EN
   localparam int unsigned IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idle_cnt;
`endif

   // Shift register with the incoming chunk appended at the LSB end
   always_comb begin
      shifted_c = (sreg << LENGTH) | 32'(bus.din);
   end

   // Receive FSM with registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         sreg        <= '0;
         count       <= '0;
         bus.dout    <= '0;
         bus.rx_done <= 1'b0;
         bus.rx_busy <= 1'b0;
         bus.rx_err  <= 1'b0;
`ifdef RX_TIMEOUT_EN
         idle_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.rx_start) begin
                  state       <= RECV;
                  sreg        <= '0;
                  count       <= '0;
                  bus.rx_busy <= 1'b1;
                  bus.rx_err  <= 1'b0;
`ifdef RX_TIMEOUT_EN
                  idle_cnt    <= '0;
`endif
               end
            end
            RECV: begin
               if (bus.rx_start) begin
                  // restart wins over a simultaneous chunk
                  sreg       <= '0;
                  count      <= '0;
                  bus.rx_err <= 1'b0;
`ifdef RX_TIMEOUT_EN
                  idle_cnt   <= '0;
`endif
               end else if (bus.din_valid) begin
                  sreg  <= shifted_c;
                  count <= count + 6'd1;
`ifdef RX_TIMEOUT_EN
                  idle_cnt <= '0;
`endif
                  if (count == LAST) begin
                     state       <= HOLD;
                     bus.dout    <= shifted_c;
                     bus.rx_done <= 1'b1;
                     bus.rx_busy <= 1'b0;
                  end
               end
`ifdef RX_TIMEOUT_EN
               else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                  // source went silent: drop the partial word
                  state       <= IDLE;
                  sreg        <= '0;
                  count       <= '0;
                  idle_cnt    <= '0;
                  bus.rx_busy <= 1'b0;
                  bus.rx_err  <= 1'b1;
               end else begin
                  idle_cnt <= idle_cnt + IW'(1);
               end
`endif
            end
            HOLD: begin
               if (bus.din_valid) begin
                  bus.rx_err <= 1'b1;
               end
               if (bus.rx_ack) begin
                  bus.rx_done <= 1'b0;
                  if (bus.rx_start) begin
                     state       <= RECV;
                     sreg        <= '0;
                     count       <= '0;
                     bus.rx_busy <= 1'b1;
                     bus.rx_err  <= 1'b0;
`ifdef RX_TIMEOUT_EN
                     idle_cnt    <= '0;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: LENGTH=4 and LENGTH=8 instances, a chunk-list
// reference model compared every cycle, plus literal expectations.
module tb_serial_receiver;
   localparam int unsigned TMO = 64;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   serial_receiver_if #(.LENGTH(4)) sif4 ();
   serial_receiver_if #(.LENGTH(8)) sif8 ();

   serial_receiver #(.LENGTH(4), .TIMEOUT(TMO)) dut4 (.clk(clk), .reset(reset), .bus(sif4));
   serial_receiver #(.LENGTH(8), .TIMEOUT(TMO)) dut8 (.clk(clk), .reset(reset), .bus(sif8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: remembers the received chunks and builds the word
   // positionally once the last one has arrived.
   typedef struct {
      int          mode;      // 0 idle, 1 receiving, 2 holding
      int          n;
      logic [31:0] ch [32];
      int          idle;
      logic [31:0] dout;
      logic        done;
      logic        busy;
      logic        err;
   } mdl_t;

   function automatic mdl_t mreset();
      mdl_t r;
      r.mode = 0; r.n = 0; r.idle = 0;
      for (int i = 0; i < 32; i++) r.ch[i] = '0;
      r.dout = '0; r.done = 1'b0; r.busy = 1'b0; r.err = 1'b0;
      return r;
   endfunction

   function automatic mdl_t step(input mdl_t m, input int len, input logic st,
                                 input logic ak, input logic dv, input logic [31:0] d);
      mdl_t        r = m;
      longint      w;
      case (m.mode)
         0: if (st) begin
               r.mode = 1; r.n = 0; r.idle = 0; r.busy = 1'b1; r.err = 1'b0;
            end
         1: begin
            if (st) begin
               r.n = 0; r.idle = 0; r.err = 1'b0;
            end else if (dv) begin
               r.ch[r.n] = d;
               r.n = r.n + 1;
               r.idle = 0;
               if (r.n == 32 / len) begin
                  w = 0;
                  for (int i = 0; i < r.n; i++)
                     w = w + (longint'(r.ch[i]) << (32 - len * (i + 1)));
                  r.dout = 32'(w);
                  r.done = 1'b1; r.busy = 1'b0; r.mode = 2;
               end
            end else begin
`ifdef RX_TIMEOUT_EN
               r.idle = r.idle + 1;
               if (r.idle == TMO) begin
                  r.mode = 0; r.busy = 1'b0; r.err = 1'b1; r.n = 0; r.idle = 0;
               end
`endif
            end
         end
         default: begin
            if (dv) r.err = 1'b1;
            if (ak) begin
               r.done = 1'b0;
               if (st) begin
                  r.mode = 1; r.n = 0; r.idle = 0; r.busy = 1'b1; r.err = 1'b0;
               end else begin
                  r.mode = 0;
               end
            end
         end
      endcase
      return r;
   endfunction

   mdl_t m4, m8;

   // Advance the model on the same edges the DUTs see
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m4 <= mreset();
         m8 <= mreset();
      end else begin
         m4 <= step(m4, 4, sif4.rx_start, sif4.rx_ack, sif4.din_valid, 32'(sif4.din));
         m8 <= step(m8, 8, sif8.rx_start, sif8.rx_ack, sif8.din_valid, 32'(sif8.din));
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (!reset) begin
         chk("m4_dout", sif4.dout, m4.dout);
         chk("m4_done", 32'(sif4.rx_done), 32'(m4.done));
         chk("m4_busy", 32'(sif4.rx_busy), 32'(m4.busy));
         chk("m4_err",  32'(sif4.rx_err),  32'(m4.err));
         chk("m8_dout", sif8.dout, m8.dout);
         chk("m8_done", 32'(sif8.rx_done), 32'(m8.done));
         chk("m8_busy", 32'(sif8.rx_busy), 32'(m8.busy));
         chk("m8_err",  32'(sif8.rx_err),  32'(m8.err));
      end
   end

   task automatic idle_inputs();
      sif4.din = '0; sif4.din_valid = 1'b0; sif4.rx_start = 1'b0; sif4.rx_ack = 1'b0;
      sif8.din = '0; sif8.din_valid = 1'b0; sif8.rx_start = 1'b0; sif8.rx_ack = 1'b0;
   endtask

   task automatic tick4(input logic st, input logic ak, input logic dv, input logic [3:0] d);
      idle_inputs();
      sif4.rx_start = st; sif4.rx_ack = ak; sif4.din_valid = dv; sif4.din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic tick8(input logic st, input logic ak, input logic dv, input logic [7:0] d);
      idle_inputs();
      sif8.rx_start = st; sif8.rx_ack = ak; sif8.din_valid = dv; sif8.din = d;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] beef [8];
   logic [7:0] cafe [4];

   initial begin
      beef[0] = 4'hD; beef[1] = 4'hE; beef[2] = 4'hA; beef[3] = 4'hD;
      beef[4] = 4'hB; beef[5] = 4'hE; beef[6] = 4'hE; beef[7] = 4'hF;
      cafe[0] = 8'hCA; cafe[1] = 8'hFE; cafe[2] = 8'hBA; cafe[3] = 8'hBE;
      reset = 1'b0;
      idle_inputs();
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", sif4.dout, 32'h0);
      chk("rst_done", 32'(sif4.rx_done), 32'h0);
      chk("rst_busy", 32'(sif4.rx_busy), 32'h0);
      chk("rst_err",  32'(sif4.rx_err),  32'h0);
      reset = 1'b0;

      // Basic word, back-to-back chunks
      tick4(1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         chk("basic_done_early", 32'(sif4.rx_done), 32'h0);
         tick4(1'b0, 1'b0, 1'b1, beef[i]);
      end
      chk("basic_dout", sif4.dout, 32'hDEADBEEF);
      chk("basic_done", 32'(sif4.rx_done), 32'h1);
      tick4(1'b1, 1'b0, 1'b0, 4'h0);
      chk("hold_start_ignored", 32'(sif4.rx_done), 32'h1);
      tick4(1'b0, 1'b1, 1'b0, 4'h0);
      chk("ack_done", 32'(sif4.rx_done), 32'h0);
      chk("ack_dout_kept", sif4.dout, 32'hDEADBEEF);

      // Gapped chunks
      tick4(1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         tick4(1'b0, 1'b0, 1'b1, beef[i]);
         if (i < 7) begin
            for (int g = 0; g < 3; g++) begin
               tick4(1'b0, 1'b0, 1'b0, 4'h0);
               chk("gap_busy", 32'(sif4.rx_busy), 32'h1);
            end
         end
      end
      chk("gap_dout", sif4.dout, 32'hDEADBEEF);
      tick4(1'b0, 1'b1, 1'b0, 4'h0);

      // Restart mid-word, then overrun in HOLD
      tick4(1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) tick4(1'b0, 1'b0, 1'b1, 4'h9);
      tick4(1'b1, 1'b0, 1'b1, 4'h1);
      for (int i = 1; i <= 8; i++) tick4(1'b0, 1'b0, 1'b1, 4'(i));
      chk("restart_dout", sif4.dout, 32'h12345678);
      tick4(1'b0, 1'b0, 1'b1, 4'hA);
      chk("overrun_err", 32'(sif4.rx_err), 32'h1);
      chk("overrun_dout", sif4.dout, 32'h12345678);
      chk("overrun_done", 32'(sif4.rx_done), 32'h1);
      tick4(1'b0, 1'b1, 1'b0, 4'h0);
      chk("err_sticky", 32'(sif4.rx_err), 32'h1);

      // Asynchronous reset in the middle of a word
      tick4(1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 5; i++) tick4(1'b0, 1'b0, 1'b1, 4'h3);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_dout", sif4.dout, 32'h0);
      chk("async_rst_busy", 32'(sif4.rx_busy), 32'h0);
      chk("async_rst_err",  32'(sif4.rx_err),  32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      tick4(1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 8; i++) tick4(1'b0, 1'b0, 1'b1, 4'hF);
      chk("post_rst_dout", sif4.dout, 32'hFFFFFFFF);
      tick4(1'b0, 1'b1, 1'b0, 4'h0);

      // LENGTH=8 word, then ack+start re-arm
      tick8(1'b1, 1'b0, 1'b0, 8'h0);
      for (int i = 0; i < 4; i++) tick8(1'b0, 1'b0, 1'b1, cafe[i]);
      chk("l8_dout", sif8.dout, 32'hCAFEBABE);
      chk("l8_done", 32'(sif8.rx_done), 32'h1);
      tick8(1'b1, 1'b1, 1'b0, 8'h0);
      chk("l8_rearm_done", 32'(sif8.rx_done), 32'h0);
      chk("l8_rearm_busy", 32'(sif8.rx_busy), 32'h1);
      for (int i = 1; i <= 4; i++) tick8(1'b0, 1'b0, 1'b1, 8'(i));
      chk("l8_dout2", sif8.dout, 32'h01020304);
      tick8(1'b0, 1'b1, 1'b0, 8'h0);

      // Silent source after two chunks
      tick4(1'b1, 1'b0, 1'b0, 4'h0);
      tick4(1'b0, 1'b0, 1'b1, 4'h5);
      tick4(1'b0, 1'b0, 1'b1, 4'h6);
      for (int i = 0; i < int'(TMO); i++) tick4(1'b0, 1'b0, 1'b0, 4'h0);
`ifdef RX_TIMEOUT_EN
      chk("tmo_busy", 32'(sif4.rx_busy), 32'h0);
      chk("tmo_err",  32'(sif4.rx_err),  32'h1);
      chk("tmo_done", 32'(sif4.rx_done), 32'h0);
`else
      repeat (8) tick4(1'b0, 1'b0, 1'b0, 4'h0);
      chk("no_tmo_busy", 32'(sif4.rx_busy), 32'h1);
`endif
      tick4(1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 8; i++) tick4(1'b0, 1'b0, 1'b1, beef[7 - i]);
      chk("final_dout", sif4.dout, 32'hFEEBDAED);
      tick4(1'b0, 1'b1, 1'b0, 4'h0);
      tick4(1'b0, 1'b0, 1'b0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
